// File: rtl/char_select_ctrl.sv
// Two-player character-select controller: per-player cursor/lock FSMs, a confirm
// countdown and a one-cycle Start_Game pulse with registered per-player stat bundles.
module char_select_ctrl #(
  parameter int unsigned NUM_CHARS      = 4,
  parameter int unsigned STAT_W         = 10,
  parameter int unsigned CONFIRM_CYCLES = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                P1_Left,
  input  logic                P1_Right,
  input  logic                P1_Confirm,
  input  logic                P1_Cancel,
  input  logic                P2_Left,
  input  logic                P2_Right,
  input  logic                P2_Confirm,
  input  logic                P2_Cancel,
  input  logic                New_Round,
  output logic [3:0]          P1_Char_Num,
  output logic [3:0]          P2_Char_Num,
  output logic                P1_Locked,
  output logic                P2_Locked,
  output logic [8*STAT_W-1:0] P1_Stats,
  output logic [8*STAT_W-1:0] P2_Stats,
  output logic                Counting,
  output logic                Start_Game,
  output logic                Done
);

  localparam logic [3:0]  LastChar = 4'(NUM_CHARS - 1);
  localparam int unsigned CntW     = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CONFIRM_CYCLES - 1);

  typedef enum logic [1:0] {StSelect, StCount, StDone} glob_e;
  typedef enum logic {StBrowse, StLocked} ply_e;

  // Packed order: H, W, JX, KX, JY, KY, HBH, HBW; unknown indices fall back to char0.
  function automatic logic [8*STAT_W-1:0] stat_lookup(input logic [3:0] idx);
    logic [8*STAT_W-1:0] s;
    case (idx)
      4'd1:    s = {STAT_W'(24), STAT_W'(16), STAT_W'(2), STAT_W'(3),
                    STAT_W'(2),  STAT_W'(2),  STAT_W'(16), STAT_W'(10)};
      4'd2:    s = {STAT_W'(16), STAT_W'(24), STAT_W'(1), STAT_W'(2),
                    STAT_W'(3),  STAT_W'(1),  STAT_W'(10), STAT_W'(16)};
      4'd3:    s = {STAT_W'(32), STAT_W'(32), STAT_W'(3), STAT_W'(1),
                    STAT_W'(1),  STAT_W'(3),  STAT_W'(20), STAT_W'(20)};
      default: s = {STAT_W'(16), STAT_W'(16), STAT_W'(1), STAT_W'(1),
                    STAT_W'(1),  STAT_W'(1),  STAT_W'(10), STAT_W'(10)};
    endcase
    return s;
  endfunction

  logic [8:0]      w_keys;
  logic [8:0]      w_rise;
  logic [8:0]      r_keys_prev;
  logic [1:0]      w_locked;
  logic [1:0]      w_unlock;
  glob_e           r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic            r_start, w_start_nxt;

  assign w_keys = {New_Round, P2_Cancel, P2_Confirm, P2_Right, P2_Left,
                   P1_Cancel, P1_Confirm, P1_Right, P1_Left};
  assign w_rise = w_keys & ~r_keys_prev;

  for (genvar g = 0; g < 2; g++) begin : g_ply
    logic [3:0]          r_char, w_char_nxt;
    ply_e                r_ply, w_ply_nxt;
    logic                w_unl;
    logic [8*STAT_W-1:0] r_stats;

    always_comb begin
      w_char_nxt = r_char;
      w_ply_nxt  = r_ply;
      w_unl      = 1'b0;
      if (r_state != StDone) begin
        if (r_ply == StBrowse) begin
          if (w_rise[4*g+2]) begin
            w_ply_nxt = StLocked;
          end else if (w_rise[4*g+1] && !w_rise[4*g]) begin
            w_char_nxt = (r_char == LastChar) ? 4'd0 : r_char + 4'd1;
          end else if (w_rise[4*g] && !w_rise[4*g+1]) begin
            w_char_nxt = (r_char == 4'd0) ? LastChar : r_char - 4'd1;
          end
        end else if (w_rise[4*g+3]) begin
          w_ply_nxt = StBrowse;
          w_unl     = 1'b1;
        end
      end else if (w_rise[8]) begin
        w_ply_nxt = StBrowse;
      end
    end

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        r_char  <= 4'(g);
        r_ply   <= StBrowse;
        r_stats <= stat_lookup(4'(g));
      end else begin
        r_char  <= w_char_nxt;
        r_ply   <= w_ply_nxt;
        r_stats <= stat_lookup(r_char);
      end
    end

    assign w_locked[g] = (r_ply == StLocked);
    assign w_unlock[g] = w_unl;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start_nxt = 1'b0;
    unique case (r_state)
      StSelect: begin
        if (&w_locked && !(|w_unlock)) begin
          w_state_nxt = StCount;
          w_cnt_nxt   = '0;
        end
      end
      StCount: begin
        // An unlock on the expiry cycle takes priority over the start pulse.
        if (|w_unlock) begin
          w_state_nxt = StSelect;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CntLast) begin
          w_state_nxt = StDone;
          w_start_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end
      StDone: begin
        if (w_rise[8]) w_state_nxt = StSelect;
      end
      default: w_state_nxt = StSelect;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_keys_prev <= '0;
      r_state     <= StSelect;
      r_cnt       <= '0;
      r_start     <= 1'b0;
    end else begin
      r_keys_prev <= w_keys;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_start     <= w_start_nxt;
    end
  end

  assign P1_Char_Num = g_ply[0].r_char;
  assign P2_Char_Num = g_ply[1].r_char;
  assign P1_Locked   = w_locked[0];
  assign P2_Locked   = w_locked[1];
  assign P1_Stats    = g_ply[0].r_stats;
  assign P2_Stats    = g_ply[1].r_stats;
  assign Counting    = (r_state == StCount);
  assign Done        = (r_state == StDone);
  assign Start_Game  = r_start;

endmodule

// File: tb/tb_char_select_ctrl.sv
// Self-checking bench for char_select_ctrl: directed scenarios plus random key traffic
// checked against a cycle-level behavioural model of the select rules.
module tb_char_select_ctrl;
  localparam int N  = 4;
  localparam int SW = 10;
  localparam int CC = 8;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic [8:0] keys = '0;
  logic P1_Left, P1_Right, P1_Confirm, P1_Cancel;
  logic P2_Left, P2_Right, P2_Confirm, P2_Cancel, New_Round;
  logic [3:0] P1_Char_Num, P2_Char_Num;
  logic P1_Locked, P2_Locked, Counting, Start_Game, Done;
  logic [8*SW-1:0] P1_Stats, P2_Stats;

  assign {New_Round, P2_Cancel, P2_Confirm, P2_Right, P2_Left,
          P1_Cancel, P1_Confirm, P1_Right, P1_Left} = keys;

  always #5 Clk = ~Clk;

  char_select_ctrl #(.NUM_CHARS(N), .STAT_W(SW), .CONFIRM_CYCLES(CC)) dut (
    .Clk(Clk), .Reset(Reset),
    .P1_Left(P1_Left), .P1_Right(P1_Right), .P1_Confirm(P1_Confirm), .P1_Cancel(P1_Cancel),
    .P2_Left(P2_Left), .P2_Right(P2_Right), .P2_Confirm(P2_Confirm), .P2_Cancel(P2_Cancel),
    .New_Round(New_Round),
    .P1_Char_Num(P1_Char_Num), .P2_Char_Num(P2_Char_Num),
    .P1_Locked(P1_Locked), .P2_Locked(P2_Locked),
    .P1_Stats(P1_Stats), .P2_Stats(P2_Stats),
    .Counting(Counting), .Start_Game(Start_Game), .Done(Done)
  );

  int checks = 0;
  int errors = 0;

  int tbl [4][8] = '{'{16, 16, 1, 1, 1, 1, 10, 10},
                     '{24, 16, 2, 3, 2, 2, 16, 10},
                     '{16, 24, 1, 2, 3, 1, 10, 16},
                     '{32, 32, 3, 1, 1, 3, 20, 20}};

  function automatic logic [8*SW-1:0] stats_of(input int idx);
    logic [1:0] i2;
    i2 = (idx >= 0 && idx < 4) ? 2'(idx) : 2'd0;
    return {SW'(tbl[i2][0]), SW'(tbl[i2][1]), SW'(tbl[i2][2]), SW'(tbl[i2][3]),
            SW'(tbl[i2][4]), SW'(tbl[i2][5]), SW'(tbl[i2][6]), SW'(tbl[i2][7])};
  endfunction

  // Model state: phase 0 = selecting, 1 = counting down, 2 = done.
  int m_char [2];
  bit m_lock [2];
  int m_phase, m_cnt;
  bit m_start;
  logic [8*SW-1:0] m_st0, m_st1;
  logic [8:0] m_prev;

  task automatic model_reset();
    m_char[0] = 0; m_char[1] = 1;
    m_lock[0] = 0; m_lock[1] = 0;
    m_phase = 0; m_cnt = 0; m_start = 0;
    m_st0 = stats_of(0); m_st1 = stats_of(1);
    m_prev = '0;
  endtask

  task automatic ply_step(inout int ch, inout bit lk, input logic [3:0] e, inout bit unl);
    if (!lk) begin
      if (e[2]) lk = 1;
      else if (e[1] && !e[0]) ch = (ch + 1) % N;
      else if (e[0] && !e[1]) ch = (ch + N - 1) % N;
    end else if (e[3]) begin
      lk = 0;
      unl = 1;
    end
  endtask

  task automatic model_step(input logic [8:0] k);
    logic [8:0] e;
    bit both, unl;
    e = k & ~m_prev;
    m_prev = k;
    both = m_lock[0] && m_lock[1];
    unl = 0;
    m_st0 = stats_of(m_char[0]);
    m_st1 = stats_of(m_char[1]);
    m_start = 0;
    if (m_phase != 2) begin
      ply_step(m_char[0], m_lock[0], e[3:0], unl);
      ply_step(m_char[1], m_lock[1], e[7:4], unl);
    end else if (e[8]) begin
      m_lock[0] = 0; m_lock[1] = 0;
    end
    case (m_phase)
      0: if (both && !unl) begin m_phase = 1; m_cnt = 0; end
      1: begin
        if (unl) begin m_phase = 0; m_cnt = 0; end
        else if (m_cnt == CC - 1) begin m_phase = 2; m_start = 1; end
        else m_cnt++;
      end
      default: if (e[8]) m_phase = 0;
    endcase
  endtask

  task automatic tick(input logic [8:0] k);
    keys = k;
    @(posedge Clk);
    model_step(k);
    #1;
  endtask

  task automatic apply_reset();
    keys = '0;
    Reset = 1'b1;
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({P1_Char_Num, P2_Char_Num, P1_Locked, P2_Locked, Counting, Start_Game, Done} !==
        {4'd0, 4'd1, 5'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got %h %h %b%b%b%b%b expected 0 1 00000", P1_Char_Num,
               P2_Char_Num, P1_Locked, P2_Locked, Counting, Start_Game, Done);
    end
    checks++;
    if (P1_Stats !== stats_of(0) || P2_Stats !== stats_of(1)) begin
      errors++;
      $display("FAIL reset_stats: got %h %h expected %h %h", P1_Stats, P2_Stats,
               stats_of(0), stats_of(1));
    end
  endtask

  task automatic test_right_wrap();
    int exp_seq [5] = '{1, 2, 3, 0, 1};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      tick(9'h002);
      checks++;
      if (P1_Char_Num !== 4'(exp_seq[i])) begin
        errors++;
        $display("FAIL right_wrap step %0d: got %0d expected %0d", i, P1_Char_Num, exp_seq[i]);
      end
      if (i == 0) begin
        checks++;
        if (P1_Stats !== stats_of(0)) begin
          errors++;
          $display("FAIL stats_latency: got %h expected %h", P1_Stats, stats_of(0));
        end
      end
      tick(9'h000);
    end
    checks++;
    if (P1_Stats !== {10'd24, 10'd16, 10'd2, 10'd3, 10'd2, 10'd2, 10'd16, 10'd10}) begin
      errors++;
      $display("FAIL right_wrap_stats: got %h expected %h", P1_Stats, stats_of(1));
    end
  endtask

  task automatic test_left_wrap();
    apply_reset();
    tick(9'h010);
    checks++;
    if (P2_Char_Num !== 4'd0) begin
      errors++; $display("FAIL left_first: got %0d expected 0", P2_Char_Num);
    end
    tick(9'h000);
    tick(9'h010);
    checks++;
    if (P2_Char_Num !== 4'd3) begin
      errors++; $display("FAIL left_wrap: got %0d expected 3", P2_Char_Num);
    end
    tick(9'h000);
    tick(9'h030);
    checks++;
    if (P2_Char_Num !== 4'd3) begin
      errors++; $display("FAIL left_right_same: got %0d expected 3", P2_Char_Num);
    end
    tick(9'h000);
  endtask

  task automatic test_lock_count();
    apply_reset();
    tick(9'h002); tick(9'h000); tick(9'h002); tick(9'h000);
    tick(9'h020); tick(9'h000);
    tick(9'h004); tick(9'h000);
    tick(9'h040);
    checks++;
    if ({P1_Char_Num, P2_Char_Num, P1_Locked, P2_Locked, Counting} !== {4'd2, 4'd2, 3'b110})
    begin
      errors++;
      $display("FAIL both_locked: got %0d %0d %b%b%b expected 2 2 110", P1_Char_Num,
               P2_Char_Num, P1_Locked, P2_Locked, Counting);
    end
    tick(9'h000);
    checks++;
    if (Counting !== 1'b1) begin
      errors++; $display("FAIL count_entry: got %b expected 1", Counting);
    end
    for (int i = 1; i <= CC; i++) begin
      tick(9'h000);
      checks++;
      if (i < CC && {Counting, Start_Game, Done} !== 3'b100) begin
        errors++;
        $display("FAIL countdown cycle %0d: got %b expected 100", i, {Counting, Start_Game, Done});
      end else if (i == CC && {Counting, Start_Game, Done} !== 3'b011) begin
        errors++;
        $display("FAIL start_pulse: got %b expected 011", {Counting, Start_Game, Done});
      end
    end
    tick(9'h000);
    checks++;
    if ({Start_Game, Done} !== 2'b01) begin
      errors++; $display("FAIL pulse_single: got %b expected 01", {Start_Game, Done});
    end
  endtask

  task automatic test_done_new_round();
    tick(9'h002); tick(9'h000); tick(9'h008); tick(9'h080); tick(9'h000);
    checks++;
    if ({P1_Char_Num, P2_Char_Num, P1_Locked, P2_Locked, Done} !== {4'd2, 4'd2, 3'b111}) begin
      errors++;
      $display("FAIL done_hold: got %0d %0d %b%b%b expected 2 2 111", P1_Char_Num, P2_Char_Num,
               P1_Locked, P2_Locked, Done);
    end
    tick(9'h100);
    checks++;
    if ({P1_Char_Num, P2_Char_Num, P1_Locked, P2_Locked, Done} !== {4'd2, 4'd2, 3'b000}) begin
      errors++;
      $display("FAIL new_round: got %0d %0d %b%b%b expected 2 2 000", P1_Char_Num, P2_Char_Num,
               P1_Locked, P2_Locked, Done);
    end
    tick(9'h000);
  endtask

  task automatic test_cancel_count();
    int n;
    bit seen;
    apply_reset();
    tick(9'h004); tick(9'h000); tick(9'h040); tick(9'h000);
    repeat (4) tick(9'h000);
    tick(9'h008);
    checks++;
    if ({P1_Locked, P2_Locked, Counting, Start_Game} !== 4'b0100) begin
      errors++;
      $display("FAIL cancel_in_count: got %b expected 0100",
               {P1_Locked, P2_Locked, Counting, Start_Game});
    end
    seen = 0;
    repeat (12) begin
      tick(9'h000);
      if (Start_Game || Counting) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL cancel_no_start: got activity 1 expected 0");
    end
    tick(9'h004);
    tick(9'h000);
    n = 0;
    while (!Start_Game && n < 40) begin
      tick(9'h000);
      n++;
    end
    checks++;
    if (n !== CC) begin
      errors++; $display("FAIL recount_length: got %0d expected %0d", n, CC);
    end
  endtask

  task automatic test_hold_and_async_reset();
    bit seen;
    apply_reset();
    repeat (20) tick(9'h002);
    checks++;
    if (P1_Char_Num !== 4'd1) begin
      errors++; $display("FAIL hold_right: got %0d expected 1", P1_Char_Num);
    end
    tick(9'h000);
    tick(9'h004); tick(9'h000); tick(9'h040); tick(9'h000);
    repeat (3) tick(9'h000);
    #2 Reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({P1_Char_Num, P2_Char_Num, P1_Locked, P2_Locked, Counting, Start_Game, Done} !==
        {4'd0, 4'd1, 5'b0}) begin
      errors++;
      $display("FAIL async_reset: got %h %h %b expected 0 1 00000", P1_Char_Num, P2_Char_Num,
               {P1_Locked, P2_Locked, Counting, Start_Game, Done});
    end
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    seen = 0;
    repeat (CC + 4) begin
      tick(9'h000);
      if (Start_Game) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL reset_no_start: got pulse 1 expected 0");
    end
  endtask

  task automatic test_random();
    logic [8:0] k;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      k[0] = ($urandom % 4) == 0;
      k[1] = ($urandom % 4) == 0;
      k[2] = ($urandom % 6) == 0;
      k[3] = ($urandom % 24) == 0;
      k[4] = ($urandom % 4) == 0;
      k[5] = ($urandom % 4) == 0;
      k[6] = ($urandom % 6) == 0;
      k[7] = ($urandom % 24) == 0;
      k[8] = ($urandom % 20) == 0;
      tick(k);
      checks++;
      if ({P1_Char_Num, P2_Char_Num, P1_Locked, P2_Locked, Counting, Start_Game, Done} !==
          {4'(m_char[0]), 4'(m_char[1]), m_lock[0], m_lock[1], m_phase == 1, m_start,
           m_phase == 2}) begin
        errors++;
        $display("FAIL random_ctrl cycle %0d: got %h %h %b expected %0d %0d %b%b%b%b%b", i,
                 P1_Char_Num, P2_Char_Num, {P1_Locked, P2_Locked, Counting, Start_Game, Done},
                 m_char[0], m_char[1], m_lock[0], m_lock[1], m_phase == 1, m_start,
                 m_phase == 2);
      end
      checks++;
      if (P1_Stats !== m_st0 || P2_Stats !== m_st1) begin
        errors++;
        $display("FAIL random_stats cycle %0d: got %h %h expected %h %h", i, P1_Stats,
                 P2_Stats, m_st0, m_st1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_right_wrap();
    test_left_wrap();
    test_lock_count();
    test_done_new_round();
    test_cancel_count();
    test_hold_and_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/char_select_ctrl.md
Name: char_select_ctrl

Overview:
Sequential character-select controller for two players, generalising the fixed one-character stat lookup to NUM_CHARS selectable characters.
- Each player moves a wrapping cursor, locks and unlocks a choice.
- Once both players are locked, a confirm countdown runs, then a one-cycle Start_Game pulse hands registered per-player stat bundles to the physics and hitbox logic.
- Sits between the keyboard decode and the player motion/collision blocks.

Parameters:
NUM_CHARS, 4, number of selectable characters (legal 2..16); cursor range 0..NUM_CHARS-1
STAT_W, 10, width of each stat field
CONFIRM_CYCLES, 8, cycles from the second lock to the Start_Game pulse (legal >=1)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
P1_Left, P1_Right, P1_Confirm, P1_Cancel  in  1 each  player 1 key levels, synchronous to Clk
P2_Left, P2_Right, P2_Confirm, P2_Cancel  in  1 each  player 2 key levels, synchronous to Clk
New_Round  in  1  level; rising edge returns the block from DONE to SELECT
P1_Char_Num, P2_Char_Num  out  4 each  current cursor or locked character index
P1_Locked, P2_Locked  out  1 each  player has locked a choice
P1_Stats, P2_Stats  out  8*STAT_W each  packed stats, MSB to LSB: Char_Height, Char_Width, Jump_X, Kick_X, Jump_Y, Kick_Y, HB_Height, HB_Width
Counting  out  1  high while the countdown runs
Start_Game  out  1  one-cycle pulse when the countdown expires
Done  out  1  high in DONE

Behaviour:
- All state is registered on the Clk rising edge and cleared asynchronously by Reset.
- Edge detection:
  - Every key input and New_Round is rising-edge detected internally, using previous-value registers that reset to 0.
  - Only edges act; held keys do nothing further.
- Reset values:
  - P1_Char_Num=0, P2_Char_Num=1.
  - Both Locked=0, Counting=0, Start_Game=0, Done=0.
  - Stats hold the table entries for characters 0 and 1.
  - Counter=0, global state SELECT.
- Stat table (H, W, JX, KX, JY, KY, HBH, HBW):
  - char0: 16,16,1,1,1,1,10,10
  - char1: 24,16,2,3,2,2,16,10
  - char2: 16,24,1,2,3,1,10,16
  - char3: 32,32,3,1,1,3,20,20
  - Any index >=4 uses the char0 values.
  - Values are zero-extended to STAT_W.
- Stats latency: PX_Stats is registered and reflects PX_Char_Num with a 1-cycle delay.
- Per-player sub-FSM, BROWSE / LOCKED (active only in SELECT and COUNT):
  - BROWSE, Right edge: cursor+1, wrapping NUM_CHARS-1 -> 0.
  - BROWSE, Left edge: cursor-1, wrapping 0 -> NUM_CHARS-1.
  - BROWSE, Left and Right edges in the same cycle: no move.
  - BROWSE, Confirm edge: go to LOCKED at the pre-move cursor. Confirm wins over Left, Right and Cancel in the same cycle.
  - BROWSE, Cancel alone: ignored.
  - LOCKED: Left and Right are ignored. A Cancel edge returns to BROWSE, and Cancel wins over Confirm. The cursor is unchanged.
  - Both players may lock the same index.
- Global FSM:
  - SELECT -> COUNT on the cycle after both Locked outputs are 1. The counter loads 0 and Counting=1.
  - COUNT:
    - The counter increments each cycle.
    - When counter==CONFIRM_CYCLES-1, go to DONE and assert Start_Game for exactly that transition cycle. The pulse occurs CONFIRM_CYCLES cycles after COUNT entry.
    - Any player unlock during COUNT returns to SELECT next cycle, with counter=0 and Counting=0. An unlock on the same cycle as expiry wins: no Start_Game is issued.
  - DONE:
    - Done=1 and Counting=0.
    - All key edges are ignored, and cursors, locks and stats are held.
    - A New_Round edge goes to SELECT: both players become BROWSE (Locked=0), cursors are kept and Done=0.
  - A New_Round edge outside DONE is ignored.
- Reset asserted mid-countdown or in DONE: immediate return to reset values, with no Start_Game pulse.
- Width: the cursor is 4 bits; the wrap comparison uses NUM_CHARS-1, so no out-of-range index is ever produced.

Test Plan:
1. Reset, then 5 P1_Right edges with NUM_CHARS=4 -> P1_Char_Num goes 1,2,3,0,1. P1_Stats equals the char1 entry (24,16,2,3,2,2,16,10) one cycle after the last move.
2. From reset, a P2_Left edge -> P2_Char_Num=0. A further P2_Left edge -> 3 (wrap). A simultaneous Left+Right edge -> still 3.
3. P1 Confirm at index 2, then P2 Confirm at index 2 -> both Locked, Counting rises, Start_Game pulses once exactly 8 cycles after COUNT entry, then Done=1.
4. During COUNT, a P1_Cancel edge on cycle 5 -> P1_Locked=0, Counting=0, no Start_Game. A later re-confirm restarts the full 8-cycle count.
5. In DONE, Right/Cancel edges are ignored and Char_Num is unchanged. A New_Round edge -> Done=0, both Locked=0, cursors kept.
6. Holding P1_Right high for 20 cycles -> exactly one move. Reset asserted mid-COUNT -> outputs take reset values asynchronously and Start_Game never fires.
